// File: rtl/aes_clk_pkg.sv
// Shared encodings and default constants for the AES clock-enable jitter controller.
package aes_clk_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_DIV    = 2'b01;
    localparam logic [1:0] MODE_RAND   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STALL  = 2'd2
    } state_e;

    localparam logic [15:0] AES_SEED_DEF  = 16'hACE1;
    localparam logic [15:0] AES_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/aes_galois_lfsr.sv
// Right-shifting Galois LFSR with synchronous reset and a parallel load that
// takes priority over the shift.
module aes_galois_lfsr
    import aes_clk_pkg::*;
#(
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = LFSR_W'(AES_LFSR_TAPS),
    parameter logic [LFSR_W-1:0]  RST_VAL   = LFSR_W'(AES_SEED_DEF)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[LFSR_W-1:1]} ^ (q_q[0] ? LFSR_TAPS : '0);
        if (load) begin
            q_d = load_val;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/aes_clk_jitter_ctrl.sv
// Clock-enable generator for the AES round logic: bypass, fixed divide, or
// LFSR-driven random stall insertion. The clock itself is never touched.
module aes_clk_jitter_ctrl
    import aes_clk_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(AES_LFSR_TAPS),
    parameter logic [LFSR_W-1:0] SEED_DEF  = LFSR_W'(AES_SEED_DEF),
    parameter int                DIV_W     = 4,
    parameter int                STALL_W   = 3,
    parameter int                MAX_STALL = 5,
    parameter int                CNT_W     = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              run,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div_ratio,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              seed_ready,
    output logic              clk_en,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int SC_W = (DIV_W > STALL_W) ? DIV_W : STALL_W;

    function automatic logic [STALL_W-1:0] clamp_stall(input logic [STALL_W-1:0] v);
        if (v > STALL_W'(MAX_STALL)) begin
            return STALL_W'(MAX_STALL);
        end
        return v;
    endfunction

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SC_W-1:0]    scnt_q, scnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               clk_en_q, busy_q, seed_ready_q;

    logic               seed_load;
    logic [LFSR_W-1:0]  seed_val;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [STALL_W-1:0] rand_len;

    // An all-zero seed would lock the LFSR, so it falls back to the default.
    assign seed_load = seed_valid && seed_ready_q;
    assign seed_val  = (seed == '0) ? SEED_DEF : seed;
    assign rand_len  = clamp_stall(lfsr_q[STALL_W:1]);

    aes_galois_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS),
        .RST_VAL   (SEED_DEF)
    ) u_lfsr (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed_val),
        .q        (lfsr_q)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        div_d       = div_q;
        scnt_d      = scnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_ACTIVE;
                    mode_d  = mode;
                    div_d   = div_ratio;
                end
            end
            S_ACTIVE: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    case (mode_q)
                        MODE_BYPASS: state_d = S_ACTIVE;
                        MODE_DIV: begin
                            if (div_q > DIV_W'(1)) begin
                                scnt_d  = SC_W'(div_q) - SC_W'(1);
                                state_d = S_STALL;
                            end
                        end
                        // MODE_RAND and the reserved encoding share this path
                        default: begin
                            if (lfsr_q[0] && (rand_len != '0)) begin
                                scnt_d  = SC_W'(rand_len);
                                state_d = S_STALL;
                            end
                        end
                    endcase
                end
            end
            S_STALL: begin
                scnt_d = scnt_q - SC_W'(1);
                if (!run) begin
                    state_d = S_IDLE;
                end else if (scnt_q <= SC_W'(1)) begin
                    state_d = S_ACTIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_BYPASS;
            div_q        <= '0;
            scnt_q       <= '0;
            stall_cnt_q  <= '0;
            clk_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            seed_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            scnt_q       <= scnt_d;
            stall_cnt_q  <= stall_cnt_d;
            clk_en_q     <= (state_d == S_ACTIVE);
            busy_q       <= (state_d != S_IDLE);
            seed_ready_q <= (state_d == S_IDLE);
        end
    end

    assign clk_en      = clk_en_q;
    assign busy        = busy_q;
    assign seed_ready  = seed_ready_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_aes_clk_jitter_ctrl.sv
// Directed bench for aes_clk_jitter_ctrl; a second instance with a 4-bit
// stall counter shares the stimulus to exercise saturation.
module tb_aes_clk_jitter_ctrl;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk_in = 1'b0;
    logic        rst, run, seed_valid;
    logic [1:0]  mode;
    logic [3:0]  div_ratio;
    logic [15:0] seed;
    logic        seed_ready, clk_en, busy;
    logic [15:0] stall_count;
    logic        seed_ready4, clk_en4, busy4;
    logic [3:0]  stall_count4;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    bit          m_idle;
    int          m_stalls;
    bit          m_en;
    int          m_rem;
    logic [59:0] seq_cur, seq_a;

    always #5 clk_in = ~clk_in;

    aes_clk_jitter_ctrl dut (
        .clk_in(clk_in), .rst(rst), .run(run), .mode(mode), .div_ratio(div_ratio),
        .seed_valid(seed_valid), .seed(seed), .seed_ready(seed_ready),
        .clk_en(clk_en), .busy(busy), .stall_count(stall_count)
    );

    aes_clk_jitter_ctrl #(.CNT_W(4)) dut4 (
        .clk_in(clk_in), .rst(rst), .run(run), .mode(mode), .div_ratio(div_ratio),
        .seed_valid(seed_valid), .seed(seed), .seed_ready(seed_ready4),
        .clk_en(clk_en4), .busy(busy4), .stall_count(stall_count4)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR and idle tracking advance with every edge.
    task automatic tick();
        if (rst) begin
            m_lfsr   = SEED;
            m_idle   = 1'b1;
            m_stalls = 0;
        end else begin
            if (m_idle && seed_valid) m_lfsr = (seed == 16'h0) ? SEED : seed;
            else                      m_lfsr = lfsr_next(m_lfsr);
            if (m_idle && run)        m_idle = 1'b0;
            else if (!m_idle && !run) m_idle = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_rand(input int n);
        logic [15:0] len;
        bit e;
        int zrun;
        tick();
        seed_valid = 1'b0;
        chk("rand_first_en", clk_en, 1);
        m_en = 1'b1; m_rem = 0; zrun = 0;
        seq_cur = '0; seq_cur[0] = 1'b1;
        for (int i = 1; i <= n; i++) begin
            len = {13'd0, m_lfsr[3:1]};
            if (len > 5) len = 5;
            if (m_en) begin
                if (m_lfsr[0] && len != 0) begin e = 1'b0; m_rem = int'(len) - 1; end
                else e = 1'b1;
            end else if (m_rem > 0) begin
                e = 1'b0; m_rem--;
            end else begin
                e = 1'b1;
            end
            tick();
            m_en = e;
            if (!e) m_stalls++;
            chk("rand_en", clk_en, e);
            zrun = clk_en ? 0 : zrun + 1;
            chk("rand_stall_le5", (zrun <= 5), 1);
            if (i < 60) seq_cur[i] = clk_en;
        end
        chk("rand_stall_count", stall_count, m_stalls);
        chk("rand_stall_count4", stall_count4, (m_stalls > 15) ? 15 : m_stalls);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; run = 1'b0; mode = 2'b00; div_ratio = 4'd0;
        seed_valid = 1'b0; seed = 16'h0;
        tick(); tick();
        chk("rst_clk_en", clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seed_ready", seed_ready, 1);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_stall_count4", stall_count4, 0);

        // Bypass
        rst = 1'b0; mode = 2'b00; run = 1'b1;
        chk("byp_pre_en", clk_en, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("byp_en", clk_en, 1);
            chk("byp_busy", busy, 1);
        end
        chk("byp_seed_ready", seed_ready, 0);
        chk("byp_stall_count", stall_count, 0);

        // Post-reset random sequence
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b10; run = 1'b1;
        run_rand(60);
        seq_a = seq_cur;

        // Zero seed reproduces the post-reset sequence
        rst = 1'b1; run = 1'b0; tick(); rst = 1'b0;
        tick();
        seed_valid = 1'b1; seed = 16'h0000;
        chk("zseed_ready", seed_ready, 1);
        tick();
        seed_valid = 1'b0;
        mode = 2'b10; run = 1'b1;
        run_rand(60);
        chk("zseed_seq_equal", {4'h0, seq_cur[59:32]}, {4'h0, seq_a[59:32]});
        chk("zseed_seq_equal_lo", seq_cur[31:0], seq_a[31:0]);

        // Seed 1 loaded together with run, long random run
        rst = 1'b1; run = 1'b0; tick(); rst = 1'b0;
        seed_valid = 1'b1; seed = 16'h0001; mode = 2'b10; run = 1'b1;
        run_rand(1000);

        // Fixed divide by 4, with mode/div changes ignored while busy
        rst = 1'b1; run = 1'b0; tick(); rst = 1'b0;
        mode = 2'b01; div_ratio = 4'd4; run = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 0) begin mode = 2'b00; div_ratio = 4'd2; end
            chk("div4_en", clk_en, (i % 4 == 0));
            chk("div4_en4", clk_en4, (i % 4 == 0));
            if (i == 15) begin
                chk("div4_stall16", stall_count, 12);
                chk("div4_stall4", stall_count4, 12);
            end
        end
        chk("div4_stall_final", stall_count, 18);
        chk("sat_stall4", stall_count4, 15);

        // Divide ratios 1 and 0 give a constant enable
        run = 1'b0; tick();
        chk("idle_busy", busy, 0);
        chk("idle_en", clk_en, 0);
        chk("idle_seed_ready", seed_ready, 1);
        mode = 2'b01; div_ratio = 4'd1; run = 1'b1;
        for (int i = 0; i < 8; i++) begin tick(); chk("div1_en", clk_en, 1); end
        run = 1'b0; tick();
        div_ratio = 4'd0; run = 1'b1;
        for (int i = 0; i < 8; i++) begin tick(); chk("div0_en", clk_en, 1); end
        chk("div01_stall", stall_count, 18);
        chk("sat_hold4", stall_count4, 15);

        // Drop run during a stall; a seed offered while busy is ignored
        rst = 1'b1; run = 1'b0; tick(); rst = 1'b0;
        mode = 2'b01; div_ratio = 4'd8; run = 1'b1;
        tick();
        chk("drop_active_en", clk_en, 1);
        tick();
        chk("drop_stall_en", clk_en, 0);
        chk("drop_stall_busy", busy, 1);
        chk("drop_stall_ready", seed_ready, 0);
        seed_valid = 1'b1; seed = 16'h1234;
        tick();
        seed_valid = 1'b0;
        run = 1'b0;
        tick();
        chk("drop_en", clk_en, 0);
        chk("drop_busy", busy, 0);
        chk("drop_ready", seed_ready, 1);
        chk("drop_stall_count", stall_count, 2);
        m_stalls = 2;
        mode = 2'b11; run = 1'b1;
        run_rand(40);

        // Reset in the middle of a stall
        run = 1'b0; tick();
        mode = 2'b01; div_ratio = 4'd8; run = 1'b1;
        tick(); tick();
        chk("mid_stall_en", clk_en, 0);
        rst = 1'b1; tick();
        chk("mrst_en", clk_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", seed_ready, 1);
        chk("mrst_stall", stall_count, 0);
        chk("mrst_stall4", stall_count4, 0);
        rst = 1'b0; run = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
